// File: rtl/hazard_stall_unit_pkg.sv
// Shared types and constants for the hazard/stall controller.
//   state_t          : controller state (RUN, MULT_WAIT)
//   REG_IDX_W        : register-index width
//   MULT_CYCLES_MAX  : upper bound on multi-cycle op length
package hazard_pkg;

  localparam int REG_IDX_W       = 5;
  localparam int MULT_CYCLES_MAX = 255;
  localparam int MULT_CNT_W      = 8;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  typedef enum logic {
    RUN       = 1'b0,
    MULT_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/hazard_stall_unit_if.sv
// Bundle of decoded ID fields, EX-stage control and pipeline-register
// enables exchanged between the pipeline and the hazard controller.
//   slave  : hazard controller side (consumes ID/EX info, drives enables)
//   master : pipeline side (drives ID/EX info, consumes enables)
interface hazard_stall_unit_if
  import hazard_pkg::*;
#(
  parameter int CNT_W = 16
);
  reg_idx_t         rsId;
  reg_idx_t         rtId;
  logic             usesRsId;
  logic             usesRtId;
  logic             memReadEx;
  logic             regWriteEx;
  reg_idx_t         rWEx;
  logic             multStartEx;
  logic             branchTakenEx;
  logic             pcWrite;
  logic             ifIdWrite;
  logic             ifIdFlush;
  logic             idExWrite;
  logic             idExBubble;
  logic             exMemWrite;
  logic             busy;
  logic [CNT_W-1:0] stallCycles;

  modport slave (
    input  rsId, rtId, usesRsId, usesRtId, memReadEx, regWriteEx, rWEx,
           multStartEx, branchTakenEx,
    output pcWrite, ifIdWrite, ifIdFlush, idExWrite, idExBubble, exMemWrite,
           busy, stallCycles
  );

  modport master (
    output rsId, rtId, usesRsId, usesRtId, memReadEx, regWriteEx, rWEx,
           multStartEx, branchTakenEx,
    input  pcWrite, ifIdWrite, ifIdFlush, idExWrite, idExBubble, exMemWrite,
           busy, stallCycles
  );

endinterface

// File: rtl/hazard_stall_unit_stall_counter.sv
// Wrapping performance counter with synchronous reset and increment enable.
//   clk, reset : clock, synchronous active-high reset
//   i_en       : increment this cycle
//   o_count    : current count
module stall_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline hazard controller: sole source of the IF/ID, ID/EX and EX/MEM
// write enables. Handles load-use stalls (1 cycle, stateless), taken-branch
// flushes and freezes during multi-cycle multiply/divide in EX.
//   clk, reset : clock, synchronous active-high reset
//   bus        : hazard_stall_unit_if.slave (ID/EX inputs, enables, busy,
//                stall-cycle counter)
module hazard_stall_unit
  import hazard_pkg::*;
#(
  parameter int MULT_CYCLES = 8,
  parameter int CNT_W       = 16
) (
  input  logic                clk,
  input  logic                reset,
  hazard_stall_unit_if.slave  bus
);

  // Detect cycle counts as the first frozen cycle, so MULT_WAIT holds for
  // MULT_CYCLES-2 further cycles before the release cycle.
  localparam logic [MULT_CNT_W-1:0] LP_WAIT_LOAD = MULT_CNT_W'(MULT_CYCLES - 2);

  state_t                r_state;
  logic [MULT_CNT_W-1:0] r_count;

  logic             w_lu;
  logic             w_pcWrite;
  logic             w_ifIdWrite;
  logic             w_ifIdFlush;
  logic             w_idExWrite;
  logic             w_idExBubble;
  logic             w_exMemWrite;
  logic             w_busy;
  logic [CNT_W-1:0] w_stallCycles;

  assign w_lu = bus.memReadEx && bus.regWriteEx && (bus.rWEx != '0) &&
                ((bus.usesRsId && (bus.rsId == bus.rWEx)) ||
                 (bus.usesRtId && (bus.rtId == bus.rWEx)));

  always_comb begin
    w_pcWrite    = 1'b1;
    w_ifIdWrite  = 1'b1;
    w_ifIdFlush  = 1'b0;
    w_idExWrite  = 1'b1;
    w_idExBubble = 1'b0;
    w_exMemWrite = 1'b1;
    w_busy       = 1'b0;
    if (reset) begin
      // Keep clocking so the pipeline fills with bubbles.
      w_ifIdFlush  = 1'b1;
      w_idExBubble = 1'b1;
    end else begin
      case (r_state)
        RUN: begin
          if (bus.multStartEx) begin
            w_pcWrite    = 1'b0;
            w_ifIdWrite  = 1'b0;
            w_idExWrite  = 1'b0;
            w_exMemWrite = 1'b0;
            w_busy       = 1'b1;
          end else if (bus.branchTakenEx) begin
            // Branch beats load-use: the stalled instruction is squashed anyway.
            w_ifIdFlush  = 1'b1;
            w_idExBubble = 1'b1;
          end else if (w_lu) begin
            w_pcWrite    = 1'b0;
            w_ifIdWrite  = 1'b0;
            w_idExBubble = 1'b1;
          end
        end
        MULT_WAIT: begin
          if (r_count != '0) begin
            w_pcWrite    = 1'b0;
            w_ifIdWrite  = 1'b0;
            w_idExWrite  = 1'b0;
            w_exMemWrite = 1'b0;
            w_busy       = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RUN;
      r_count <= '0;
    end else begin
      case (r_state)
        RUN: begin
          if (bus.multStartEx) begin
            r_state <= MULT_WAIT;
            r_count <= LP_WAIT_LOAD;
          end
        end
        MULT_WAIT: begin
          if (r_count == '0) begin
            r_state <= RUN;
          end else begin
            r_count <= r_count - 1'b1;
          end
        end
        default: begin
          r_state <= RUN;
          r_count <= '0;
        end
      endcase
    end
  end

  stall_counter #(
    .CNT_W(CNT_W)
  ) u_stall_counter (
    .clk    (clk),
    .reset  (reset),
    .i_en   (~w_pcWrite),
    .o_count(w_stallCycles)
  );

  assign bus.pcWrite     = w_pcWrite;
  assign bus.ifIdWrite   = w_ifIdWrite;
  assign bus.ifIdFlush   = w_ifIdFlush;
  assign bus.idExWrite   = w_idExWrite;
  assign bus.idExBubble  = w_idExBubble;
  assign bus.exMemWrite  = w_exMemWrite;
  assign bus.busy        = w_busy;
  assign bus.stallCycles = w_stallCycles;

endmodule
